cache_nway_ctrl: RTL and testbench
==================================

# cache_nway_ctrl

Parametrised N-way set-associative, write-back, write-allocate data-cache controller with pseudo-LRU replacement and byte-strobe writes. It sits between the CPU load/store unit and the line-wide memory port. It is the generalised successor of the fixed 2-way, 32-set, 4-word controller: ways, sets and line length are configurable, and both ports use valid/ready handshakes.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `WAYS`, 2, associativity; power of 2, 1..8.
- `SETS`, 32, sets per way; power of 2, ≥2.
- `LINE_WORDS`, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req_valid` in 1: request present.
- `cpu_req_ready` out 1: request accepted when both are high.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in ADDR_WIDTH: byte address; bits [1:0] ignored.
- `cpu_wdata` in 32: store data, already lane-aligned.
- `cpu_wstrb` in 4: store byte enables.
- `cpu_resp_valid` out 1: one-cycle pulse when the request completes (load or store).
- `cpu_rdata` out 32: load word, valid with `cpu_resp_valid`.
- `mem_req_valid` out 1: memory request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_we` out 1: 1 = line write-back, 0 = line fill.
- `mem_addr` out ADDR_WIDTH: line-aligned address.
- `mem_wdata` out 32·LINE_WORDS: victim line, word 0 in the LSBs.
- `mem_rvalid` in 1: fill data present; single beat.
- `mem_rdata` in 32·LINE_WORDS: fill line.

## Operation
- Address split: offset = log2(4·LINE_WORDS) bits; index = log2(SETS) bits; tag = remainder.
- States: IDLE, LOOKUP, WBACK, REFILL.
- **IDLE:** `cpu_req_ready`=1. On handshake, register addr, we, wdata and wstrb, then go to LOOKUP.
- **LOOKUP, hit:**
  - Load: register the selected word into `cpu_rdata`.
  - Store: merge bytes per `wstrb` and set dirty; `wstrb`=0 leaves data and dirty unchanged.
  - Update PLRU, pulse `cpu_resp_valid`, go to IDLE.
- **LOOKUP, miss:**
  - Victim selection: lowest-index invalid way; if all ways are valid, the PLRU victim.
  - Victim valid and dirty: go to WBACK.
  - Otherwise: go to REFILL.
- **WBACK:**
  - Drive `mem_req_valid`=1, `mem_we`=1, `mem_addr`={victim tag, index, 0} and `mem_wdata`=victim line.
  - All four are held stable until `mem_req_ready`; write-back completes on that handshake.
  - Then go to REFILL.
- **REFILL:**
  - Drive `mem_req_valid`=1, `mem_we`=0 and the request line address until `mem_req_ready`.
  - Then drop `mem_req_valid` and wait for `mem_rvalid`.
  - On `mem_rvalid`: write the line into the victim way and set valid and the tag.
  - Store request: merge the store data in the same cycle and set dirty. Load request: dirty=0 and `cpu_rdata` takes the word from `mem_rdata`.
  - Update PLRU, pulse `cpu_resp_valid`, go to IDLE.
- **PLRU:** tree of WAYS−1 bits per set, updated on every hit and fill to point away from the accessed way. WAYS=1 has no PLRU bits and the victim is always way 0.
- **Ignored memory inputs:** `mem_rvalid` outside REFILL-wait, and `mem_req_ready` while `mem_req_valid`=0.
- **Reset values:**
  - Outputs: `cpu_req_ready`=0 while `rst_n`=0 and 1 after reset; `cpu_resp_valid`, `cpu_rdata`, `mem_req_valid`, `mem_we`, `mem_addr` and `mem_wdata` all 0.
  - Internal: valid, dirty and PLRU bits all 0; state IDLE.
  - Reset mid-miss drops `mem_req_valid` asynchronously; the in-flight request and line are lost, with no partial install.

## Timing
- Hit: accept at cycle T, LOOKUP at T+1, `cpu_resp_valid` at T+2. `cpu_req_ready`=1 at T+2, giving back-to-back hits one per 2 cycles.
- Clean miss: `cpu_resp_valid` in the cycle after the `mem_rvalid` cycle.
- Dirty miss: additionally waits for the write-back handshake before the fill request issues.
- `cpu_req_ready`=0 in every state except IDLE.

## Configuration
- `CACHE_PERF_CNT_EN` defined: adds output ports `perf_hits` [31:0], `perf_misses` [31:0] and `perf_writebacks` [31:0].
  - Each increments once per event: LOOKUP hit, LOOKUP miss, WBACK handshake.
  - Counters saturate at 0xFFFF_FFFF and reset to 0.
- `CACHE_PERF_CNT_EN` undefined: the ports and counters are absent and all other behaviour is identical.

## Structure
- Package `cache_pkg`: state enum, and functions deriving offset, index, tag and PLRU widths from the parameters.
- Sub-module `cache_set_array`: per-way tag/valid/dirty/data storage.
  - Combinational read of all ways at an index.
  - Single write port with way select and per-byte enables.
- The controller holds the FSM, PLRU array, victim selection and store merge.

## Test plan
All scenarios use the defaults: WAYS=2, SETS=32, LINE_WORDS=4.
- Reset, then load 0x1004; fill returns 0x00000044_00000033_00000022_00000011 → one fill request to 0x1000 (`mem_we`=0), `cpu_rdata`=0x00000022, no write-back.
- Repeat load 0x1004 → `cpu_resp_valid` 2 cycles after accept, no memory request.
- Store 0xDEADBEEF with `wstrb`=0011 to 0x1004, then load 0x1004 → 0x0000BEEF, no memory traffic.
- Load 0x3004 (miss, fills way 1), then load 0x5004 → write-back to 0x1000 whose word 1 = 0x0000BEEF, then fill 0x5000.
- Store miss to 0x7008 with `wstrb`=1000, `wdata`=0xAB000000, fill of all zeros → later load 0x7008 = 0xAB000000 and the line is dirty.
- Assert `rst_n` low during REFILL-wait → `mem_req_valid` falls immediately; after reset, load 0x1004 misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the N-way data-cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WBACK  = 2'd2,
        ST_REFILL = 2'd3
    } cache_state_e;

    function automatic int offset_bits(input int line_words);
        return $clog2(4 * line_words);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int sets, input int line_words);
        return addr_width - index_bits(sets) - offset_bits(line_words);
    endfunction

    // Way-select width; a direct-mapped cache still carries one (constant) bit.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Depth of the PLRU tree; zero for a direct-mapped cache.
    function automatic int plru_levels(input int ways);
        return (ways > 1) ? $clog2(ways) : 0;
    endfunction

    // Number of live PLRU tree bits per set.
    function automatic int plru_bits(input int ways);
        return (ways > 1) ? ways - 1 : 0;
    endfunction

endpackage

// File: rtl/cache_nway_ctrl_set_array.sv
// Per-way tag/valid/dirty/data storage. All ways of one set are read
// combinationally; one write port with way select and byte enables.
module cache_nway_ctrl_set_array
    import cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 23,
    parameter int IDX_W      = 5,
    parameter int WB         = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [IDX_W-1:0]                   rd_idx,
    output logic [WAYS-1:0][TAG_W-1:0]         rd_tag,
    output logic [WAYS-1:0]                    rd_valid,
    output logic [WAYS-1:0]                    rd_dirty,
    output logic [WAYS-1:0][32*LINE_WORDS-1:0] rd_data,
    input  logic                               wr_en,
    input  logic [WB-1:0]                      wr_way,
    input  logic [IDX_W-1:0]                   wr_idx,
    input  logic [TAG_W-1:0]                   wr_tag,
    input  logic                               wr_dirty,
    input  logic [32*LINE_WORDS-1:0]           wr_data,
    input  logic [4*LINE_WORDS-1:0]            wr_be
);

    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int BE_W   = 4 * LINE_WORDS;

    logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
    logic [LINE_W-1:0] data_mem  [WAYS][SETS];
    logic [WAYS-1:0]   valid_mem [SETS];
    logic [WAYS-1:0]   dirty_mem [SETS];

    // Combinational read of every way at the requested set.
    always_comb begin
        rd_tag  = '0;
        rd_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_tag[w]  = tag_mem[w][rd_idx];
            rd_data[w] = data_mem[w][rd_idx];
        end
        rd_valid = valid_mem[rd_idx];
        rd_dirty = dirty_mem[rd_idx];
    end

    // Status bits: cleared by reset, any write marks the line valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
            end
        end else if (wr_en) begin
            valid_mem[wr_idx][wr_way] <= 1'b1;
            dirty_mem[wr_idx][wr_way] <= wr_dirty;
        end
    end

    // Tag and data payload; only meaningful behind a valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_way][wr_idx] <= wr_tag;
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_way][wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative write-back / write-allocate data-cache controller
// with tree pseudo-LRU replacement and byte-strobe stores.
// Optional build macro: CACHE_PERF_CNT_EN adds saturating hit/miss/write-back
// counters on ports perf_hits, perf_misses and perf_writebacks.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a CPU request; latches it on handshake
// LOOKUP  | tag compare; hit completes, miss picks a victim
// WBACK   | dirty victim line offered to memory until accepted
// REFILL  | fill request until accepted, then wait for the fill beat
module cache_nway_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [31:0]             cpu_wdata,
    input  logic [3:0]              cpu_wstrb,
    output logic                    cpu_resp_valid,
    output logic [31:0]             cpu_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [32*LINE_WORDS-1:0] mem_rdata
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]             perf_hits,
    output logic [31:0]             perf_misses,
    output logic [31:0]             perf_writebacks
`endif
);

    localparam int OFF_W   = offset_bits(LINE_WORDS);
    localparam int IDX_W   = index_bits(SETS);
    localparam int TAG_W   = tag_bits(ADDR_WIDTH, SETS, LINE_WORDS);
    localparam int WB      = way_bits(WAYS);
    localparam int LVL     = plru_levels(WAYS);
    localparam int PLRU_SW = 1 << WB;
    localparam int WSEL_W  = $clog2(LINE_WORDS);
    localparam int LINE_W  = 32 * LINE_WORDS;
    localparam int BE_W    = 4 * LINE_WORDS;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_LOOKUP = ST_LOOKUP;
    localparam logic [1:0] S_WBACK  = ST_WBACK;
    localparam logic [1:0] S_REFILL = ST_REFILL;

    logic [1:0]              state;
    logic [ADDR_WIDTH-1:2]   req_addr;
    logic                    req_we;
    logic [31:0]             req_wdata;
    logic [3:0]              req_wstrb;
    logic [WB-1:0]           victim_q;
    logic                    fill_sent;
    logic [PLRU_SW-1:0]      plru_mem [SETS];

    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        req_idx;
    logic [WSEL_W-1:0]       req_wsel;

    logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
    logic [WAYS-1:0]             rd_valid;
    logic [WAYS-1:0]             rd_dirty;
    logic [WAYS-1:0][LINE_W-1:0] rd_data;

    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WB-1:0]     hit_way;
    logic [WB-1:0]     inv_way;
    logic [WB-1:0]     plru_victim;
    logic [WB-1:0]     victim;
    logic [WB-1:0]     acc_way;
    logic [PLRU_SW-1:0] cur_plru;
    logic [PLRU_SW-1:0] plru_upd;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic [31:0]       fill_word;
    logic [BE_W-1:0]   st_be;
    logic [LINE_W-1:0] fill_merged;
    logic              lookup_hit;
    logic              fill_fire;

    logic              arr_we;
    logic [WB-1:0]     arr_way;
    logic              arr_dirty;
    logic [LINE_W-1:0] arr_data;
    logic [BE_W-1:0]   arr_be;

    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_wsel = req_addr[2 +: WSEL_W];
    assign cur_plru = plru_mem[req_idx];

    assign lookup_hit = (state == S_LOOKUP) && hit;
    assign fill_fire  = (state == S_REFILL) && fill_sent && mem_rvalid;

    // Ready is gated by rst_n so it reads 0 for the whole reset interval.
    assign cpu_req_ready = rst_n && (state == S_IDLE);

    cache_nway_ctrl_set_array #(
        .WAYS       (WAYS),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .WB         (WB)
    ) u_set_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (req_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_data  (rd_data),
        .wr_en    (arr_we),
        .wr_way   (arr_way),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_dirty (arr_dirty),
        .wr_data  (arr_data),
        .wr_be    (arr_be)
    );

    // Tag compare and victim choice: lowest invalid way, else the PLRU pick.
    always_comb begin
        logic [WB-1:0] node;
        hit_vec     = '0;
        hit_way     = '0;
        inv_way     = '0;
        plru_victim = '0;
        node        = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = rd_valid[w] && (rd_tag[w] == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WB'(w);
            if (!rd_valid[w]) inv_way = WB'(w);
        end
        for (int l = 0; l < LVL; l++) begin
            plru_victim[LVL-1-l] = cur_plru[node];
            node = WB'(2 * int'(node) + 1 + int'(cur_plru[node]));
        end
        hit    = |hit_vec;
        victim = (&rd_valid) ? plru_victim : inv_way;
    end

    // PLRU update: each tree node on the accessed path points to the other half.
    always_comb begin
        logic [WB-1:0] node;
        logic          dir;
        acc_way  = lookup_hit ? hit_way : victim_q;
        plru_upd = cur_plru;
        node     = '0;
        dir      = 1'b0;
        for (int l = 0; l < LVL; l++) begin
            dir            = acc_way[LVL-1-l];
            plru_upd[node] = ~dir;
            node           = WB'(2 * int'(node) + 1 + int'(dir));
        end
    end

    // Word selection for loads and byte-lane placement for stores.
    always_comb begin
        hit_line  = rd_data[hit_way];
        hit_word  = '0;
        fill_word = '0;
        st_be     = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (WSEL_W'(w) == req_wsel) begin
                hit_word         = hit_line[32*w +: 32];
                fill_word        = mem_rdata[32*w +: 32];
                st_be[4*w +: 4]  = req_wstrb;
            end
        end
        fill_merged = '0;
        for (int b = 0; b < BE_W; b++) begin
            fill_merged[8*b +: 8] = (req_we && st_be[b]) ? req_wdata[8*(b%4) +: 8]
                                                         : mem_rdata[8*b +: 8];
        end
    end

    // Storage write: store hit merges in place, fill installs the whole line.
    always_comb begin
        arr_we    = 1'b0;
        arr_way   = hit_way;
        arr_dirty = rd_dirty[hit_way] | (|req_wstrb);
        arr_data  = {LINE_WORDS{req_wdata}};
        arr_be    = st_be;
        if (lookup_hit && req_we) begin
            arr_we = 1'b1;
        end else if (fill_fire) begin
            arr_we    = 1'b1;
            arr_way   = victim_q;
            arr_dirty = req_we;
            arr_data  = fill_merged;
            arr_be    = '1;
        end
    end

    // Memory port driven straight from state so reset drops requests at once.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (state == S_WBACK) begin
            mem_req_valid = 1'b1;
            mem_we        = 1'b1;
            mem_addr      = {rd_tag[victim_q], req_idx, {OFF_W{1'b0}}};
            mem_wdata     = rd_data[victim_q];
        end else if (state == S_REFILL) begin
            mem_req_valid = !fill_sent;
            mem_addr      = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
    end

    // Main controller FSM and request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            req_addr       <= '0;
            req_we         <= 1'b0;
            req_wdata      <= '0;
            req_wstrb      <= '0;
            victim_q       <= '0;
            fill_sent      <= 1'b0;
            cpu_rdata      <= '0;
            cpu_resp_valid <= 1'b0;
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        req_addr  <= cpu_addr[ADDR_WIDTH-1:2];
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        req_wstrb <= cpu_wstrb;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (!req_we) cpu_rdata <= hit_word;
                        cpu_resp_valid <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        victim_q  <= victim;
                        fill_sent <= 1'b0;
                        state     <= (rd_valid[victim] && rd_dirty[victim]) ? S_WBACK : S_REFILL;
                    end
                end
                S_WBACK: begin
                    if (mem_req_ready) state <= S_REFILL;
                end
                S_REFILL: begin
                    if (!fill_sent) begin
                        if (mem_req_ready) fill_sent <= 1'b1;
                    end else if (mem_rvalid) begin
                        if (!req_we) cpu_rdata <= fill_word;
                        cpu_resp_valid <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // PLRU bits per set, touched on every hit and every fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) plru_mem[s] <= '0;
        end else if (lookup_hit || fill_fire) begin
            plru_mem[req_idx] <= plru_upd;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            if (lookup_hit && (perf_hits != 32'hFFFF_FFFF))
                perf_hits <= perf_hits + 32'd1;
            if ((state == S_LOOKUP) && !hit && (perf_misses != 32'hFFFF_FFFF))
                perf_misses <= perf_misses + 32'd1;
            if ((state == S_WBACK) && mem_req_ready && (perf_writebacks != 32'hFFFF_FFFF))
                perf_writebacks <= perf_writebacks + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl at the default geometry (2 ways,
// 32 sets, 4-word lines). All addresses used map to set 0.
module tb_cache_nway_ctrl;

    logic         clk;
    logic         rst_n;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_wstrb;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;

    int n_checks;
    int n_errors;

    int           n_wb;
    int           n_fill;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [31:0]  fill_addr;
    logic         resp_seen;
    logic [31:0]  rdata_seen;
    int           lat_seen;
    logic         ready_at_resp;

    cache_nway_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_wstrb      (cpu_wstrb),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One CPU access from a negedge; services write-back and fill requests
    // with immediate ready and a fill beat the cycle after the handshake.
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [127:0] fill);
        int  cyc;
        int  lat;
        logic pend;
        n_wb = 0; n_fill = 0; wb_addr = '0; wb_data = '0; fill_addr = '0;
        resp_seen = 1'b0; rdata_seen = '0; lat_seen = 0; ready_at_resp = 1'b0;
        pend = 1'b0;
        cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = strb;
        cyc = 0;
        while (!cpu_req_ready && cyc < 20) begin
            @(posedge clk); @(negedge clk); cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 60 && !resp_seen; i++) begin
            mem_req_ready = 1'b0;
            mem_rvalid    = 1'b0;
            if (cpu_resp_valid) begin
                resp_seen     = 1'b1;
                rdata_seen    = cpu_rdata;
                lat_seen      = lat;
                ready_at_resp = cpu_req_ready;
            end else begin
                if (mem_req_valid) begin
                    if (mem_we) begin
                        n_wb++; wb_addr = mem_addr; wb_data = mem_wdata;
                    end else begin
                        n_fill++; fill_addr = mem_addr; pend = 1'b1;
                    end
                    mem_req_ready = 1'b1;
                end else if (pend) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = fill;
                    pend       = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
        end
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        check("resp_timeout", {127'd0, resp_seen}, 128'd1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0;
        cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        @(negedge clk); @(negedge clk);
        check("rst_ready",     {127'd0, cpu_req_ready}, 128'd0);
        check("rst_resp",      {127'd0, cpu_resp_valid}, 128'd0);
        check("rst_rdata",     {96'd0, cpu_rdata}, 128'd0);
        check("rst_mem_valid", {127'd0, mem_req_valid}, 128'd0);
        check("rst_mem_addr",  {96'd0, mem_addr}, 128'd0);
        check("rst_mem_wdata", mem_wdata, 128'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {127'd0, cpu_req_ready}, 128'd1);
        @(negedge clk);

        // Cold miss fills way 0.
        cpu_access(1'b0, 32'h1004, '0, 4'h0, 128'h00000044_00000033_00000022_00000011);
        check("ld1_rdata", {96'd0, rdata_seen}, 128'h22);
        check("ld1_fills", n_fill, 1);
        check("ld1_fill_addr", {96'd0, fill_addr}, 128'h1000);
        check("ld1_wbs", n_wb, 0);

        // Hit: response two cycles after accept, no memory traffic.
        cpu_access(1'b0, 32'h1004, '0, 4'h0, '0);
        check("ld2_rdata", {96'd0, rdata_seen}, 128'h22);
        check("ld2_lat", lat_seen, 2);
        check("ld2_ready", {127'd0, ready_at_resp}, 128'd1);
        check("ld2_mem", n_fill + n_wb, 0);

        // Store hit with low-half strobe, then read back.
        cpu_access(1'b1, 32'h1004, 32'hDEADBEEF, 4'b0011, '0);
        check("st3_lat", lat_seen, 2);
        check("st3_mem", n_fill + n_wb, 0);
        cpu_access(1'b0, 32'h1004, '0, 4'h0, '0);
        check("ld4_rdata", {96'd0, rdata_seen}, 128'h0000BEEF);
        check("ld4_mem", n_fill + n_wb, 0);

        // Second line in set 0 goes to the free way 1.
        cpu_access(1'b0, 32'h3004, '0, 4'h0, 128'h00003303_00003302_00003301_00003300);
        check("ld5_rdata", {96'd0, rdata_seen}, 128'h3301);
        check("ld5_wbs", n_wb, 0);
        check("ld5_fill_addr", {96'd0, fill_addr}, 128'h3000);

        // PLRU picks way 0, which is dirty: write-back then fill.
        cpu_access(1'b0, 32'h5004, '0, 4'h0, 128'h00005503_00005502_00005501_00005500);
        check("ld6_wbs", n_wb, 1);
        check("ld6_wb_addr", {96'd0, wb_addr}, 128'h1000);
        check("ld6_wb_data", wb_data, 128'h00000044_00000033_0000BEEF_00000011);
        check("ld6_fill_addr", {96'd0, fill_addr}, 128'h5000);
        check("ld6_rdata", {96'd0, rdata_seen}, 128'h5501);

        // Store miss evicts clean way 1 and merges into the fill.
        cpu_access(1'b1, 32'h7008, 32'hAB000000, 4'b1000, 128'd0);
        check("st7_wbs", n_wb, 0);
        check("st7_fill_addr", {96'd0, fill_addr}, 128'h7000);
        cpu_access(1'b0, 32'h7008, '0, 4'h0, '0);
        check("ld8_rdata", {96'd0, rdata_seen}, 128'hAB000000);
        check("ld8_mem", n_fill + n_wb, 0);

        // Evict clean way 0, then the dirty 0x7000 line in way 1.
        cpu_access(1'b0, 32'h9004, '0, 4'h0, 128'h00009903_00009902_00009901_00009900);
        check("ld9_wbs", n_wb, 0);
        check("ld9_rdata", {96'd0, rdata_seen}, 128'h9901);
        cpu_access(1'b0, 32'hB004, '0, 4'h0, 128'h0000BB03_0000BB02_0000BB01_0000BB00);
        check("ld10_wbs", n_wb, 1);
        check("ld10_wb_addr", {96'd0, wb_addr}, 128'h7000);
        check("ld10_wb_data", wb_data, 128'h00000000_AB000000_00000000_00000000);
        check("ld10_rdata", {96'd0, rdata_seen}, 128'hBB01);

        // Store with no strobes leaves the data untouched.
        cpu_access(1'b1, 32'hB004, 32'hFFFFFFFF, 4'b0000, '0);
        check("st11_mem", n_fill + n_wb, 0);
        cpu_access(1'b0, 32'hB004, '0, 4'h0, '0);
        check("ld12_rdata", {96'd0, rdata_seen}, 128'hBB01);

        // Reset while a fill request is outstanding.
        cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1004; cpu_wstrb = 4'h0;
        @(posedge clk); @(negedge clk);
        cpu_req_valid = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!mem_req_valid && cyc < 20) begin
                @(posedge clk); @(negedge clk); cyc++;
            end
        end
        check("rf_req_valid", {127'd0, mem_req_valid}, 128'd1);
        check("rf_req_we", {127'd0, mem_we}, 128'd0);
        check("rf_req_addr", {96'd0, mem_addr}, 128'h1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {127'd0, mem_req_valid}, 128'd0);
        check("rst_mid_ready", {127'd0, cpu_req_ready}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_access(1'b0, 32'h1004, '0, 4'h0, 128'h00000044_00000033_00000077_00000011);
        check("ld13_fills", n_fill, 1);
        check("ld13_wbs", n_wb, 0);
        check("ld13_fill_addr", {96'd0, fill_addr}, 128'h1000);
        check("ld13_rdata", {96'd0, rdata_seen}, 128'h77);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
